// File: rtl/ct_mmu_jtlb_resp.sv
// Responder end of the MMU arbiter->jTLB request path: RAM pass-through, 4K->2M->1G re-lookup
// sequencing and completion return. Optional macro CT_MMU_JTLB_PERF_EN adds hit/miss counters.
module ct_mmu_jtlb_resp #(
    parameter int VPN_WIDTH = 27,
    parameter int IDX_WIDTH = 9,
    parameter int BANK_NUM  = 4
) (
    input  logic                 forever_cpuclk,
    input  logic                 cpurst_b,
    input  logic                 arb_jtlb_req,
    input  logic [2:0]           arb_jtlb_acc_type,
    input  logic [VPN_WIDTH:0]   arb_jtlb_vpn,
    input  logic [IDX_WIDTH-1:0] arb_jtlb_idx,
    input  logic [BANK_NUM-1:0]  arb_jtlb_bank_sel,
    input  logic                 arb_jtlb_write,
    input  logic                 arb_jtlb_cmp_with_va,
    output logic                 jtlb_ram_cen,
    output logic                 jtlb_ram_wen,
    output logic [IDX_WIDTH-1:0] jtlb_ram_idx,
    output logic [BANK_NUM-1:0]  jtlb_ram_bank,
    input  logic [BANK_NUM-1:0]  ram_hit,
    input  logic                 ram_par_err,
    output logic                 jtlb_arb_sel_4k,
    output logic                 jtlb_arb_sel_2m,
    output logic                 jtlb_arb_sel_1g,
    output logic                 jtlb_arb_tc_miss,
    output logic                 jtlb_arb_par_clr,
    output logic [VPN_WIDTH:0]   jtlb_arb_vpn,
    output logic [2:0]           jtlb_arb_type,
    output logic                 jtlb_arb_cmp_va,
    output logic                 jtlb_iutlb_cmplt,
    output logic                 jtlb_dutlb_cmplt,
    output logic                 jtlb_arb_pfu_cmplt,
    output logic                 jtlb_tlboper_cmplt,
    output logic                 jtlb_xx_hit,
    output logic [BANK_NUM-1:0]  jtlb_xx_hit_bank,
`ifdef CT_MMU_JTLB_PERF_EN
    output logic [31:0]          jtlb_perf_hit_cnt,
    output logic [31:0]          jtlb_perf_miss_cnt,
`endif
    output logic                 jtlb_err_lookup_ovr
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_S2M    = 2'd1,
        ST_S1G    = 2'd2,
        ST_PARCLR = 2'd3
    } state_t;

    // sel vectors are ordered {1g, 2m, 4k}
    localparam logic [2:0] SEL_4K   = 3'b001;
    localparam logic [2:0] SEL_2M   = 3'b010;
    localparam logic [2:0] SEL_1G   = 3'b100;
    localparam logic [2:0] SEL_NONE = 3'b000;

    // Completion routing, ordered {iutlb, dutlb, pfu, tlboper}
    function automatic logic [3:0] cmplt_route(input logic [2:0] acc_type);
        logic [3:0] route;
        case (acc_type)
            3'b011:  route = 4'b1000;
            3'b010:  route = 4'b0100;
            3'b110:  route = 4'b0100;
            3'b100:  route = 4'b0010;
            3'b001:  route = 4'b0001;
            default: route = 4'b0000;
        endcase
        return route;
    endfunction

    // The parity-clear pass advertises the size that errored, shifted one step up
    function automatic logic [2:0] err_sel(input state_t st);
        logic [2:0] sel;
        case (st)
            ST_IDLE: sel = SEL_2M;
            ST_S2M:  sel = SEL_1G;
            default: sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    state_t                state_r;
    state_t                state_nxt_s;
    logic [2:0]            sel_r;
    logic [2:0]            sel_nxt_s;
    logic                  tc_miss_r;
    logic                  tc_miss_nxt_s;
    logic                  par_clr_r;
    logic                  par_clr_nxt_s;
    logic                  done_nxt_s;
    logic                  hit_nxt_s;
    logic [BANK_NUM-1:0]   hit_bank_nxt_s;
    logic [3:0]            cmplt_nxt_s;
    logic [3:0]            cmplt_r;
    logic                  hit_r;
    logic [BANK_NUM-1:0]   hit_bank_r;
    logic                  s2_vld_r;
    logic [2:0]            s2_type_r;
    logic [VPN_WIDTH:0]    s2_vpn_r;
    logic                  s2_cmp_va_r;
    logic                  err_ovr_r;
    logic                  lookup_s;
    logic                  lookup_acc_s;
    logic                  hit_any_s;

    assign jtlb_ram_cen  = arb_jtlb_req;
    assign jtlb_ram_wen  = arb_jtlb_req & arb_jtlb_write;
    assign jtlb_ram_idx  = arb_jtlb_idx;
    assign jtlb_ram_bank = arb_jtlb_bank_sel;

    // Only an idle FSM or the re-lookup slot right after tc_miss may take a new lookup
    assign lookup_s     = arb_jtlb_req & arb_jtlb_cmp_with_va;
    assign lookup_acc_s = lookup_s & ~s2_vld_r & ((state_r == ST_IDLE) | tc_miss_r);
    assign hit_any_s    = |ram_hit;

    // Next-state and registered-output decode from the stage-2 RAM result
    always_comb begin
        state_nxt_s    = state_r;
        sel_nxt_s      = sel_r;
        tc_miss_nxt_s  = 1'b0;
        par_clr_nxt_s  = 1'b0;
        done_nxt_s     = 1'b0;
        hit_nxt_s      = 1'b0;
        hit_bank_nxt_s = '0;
        case (state_r)
            ST_PARCLR: begin
                state_nxt_s = ST_IDLE;
                sel_nxt_s   = SEL_4K;
                done_nxt_s  = 1'b1;
            end
            ST_IDLE, ST_S2M, ST_S1G: begin
                if (s2_vld_r) begin
                    if (ram_par_err) begin
                        state_nxt_s   = ST_PARCLR;
                        par_clr_nxt_s = 1'b1;
                        sel_nxt_s     = err_sel(state_r);
                    end else if (hit_any_s) begin
                        state_nxt_s    = ST_IDLE;
                        sel_nxt_s      = SEL_4K;
                        done_nxt_s     = 1'b1;
                        hit_nxt_s      = 1'b1;
                        hit_bank_nxt_s = ram_hit;
                    end else if (state_r == ST_IDLE) begin
                        state_nxt_s   = ST_S2M;
                        sel_nxt_s     = SEL_2M;
                        tc_miss_nxt_s = 1'b1;
                    end else if (state_r == ST_S2M) begin
                        state_nxt_s   = ST_S1G;
                        sel_nxt_s     = SEL_1G;
                        tc_miss_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        sel_nxt_s   = SEL_4K;
                        done_nxt_s  = 1'b1;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                sel_nxt_s   = SEL_4K;
            end
        endcase
        cmplt_nxt_s = done_nxt_s ? cmplt_route(s2_type_r) : 4'b0000;
    end

    // FSM state and registered feedback/completion outputs
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state_r    <= ST_IDLE;
            sel_r      <= SEL_4K;
            tc_miss_r  <= 1'b0;
            par_clr_r  <= 1'b0;
            cmplt_r    <= 4'b0000;
            hit_r      <= 1'b0;
            hit_bank_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            sel_r      <= sel_nxt_s;
            tc_miss_r  <= tc_miss_nxt_s;
            par_clr_r  <= par_clr_nxt_s;
            cmplt_r    <= cmplt_nxt_s;
            hit_r      <= hit_nxt_s;
            hit_bank_r <= hit_bank_nxt_s;
        end
    end

    // Stage-2 capture of the accepted lookup, plus the sticky dropped-lookup flag
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            s2_vld_r    <= 1'b0;
            s2_type_r   <= 3'b000;
            s2_vpn_r    <= '0;
            s2_cmp_va_r <= 1'b0;
            err_ovr_r   <= 1'b0;
        end else begin
            s2_vld_r <= lookup_acc_s;
            if (lookup_acc_s) begin
                s2_type_r   <= arb_jtlb_acc_type;
                s2_vpn_r    <= arb_jtlb_vpn;
                s2_cmp_va_r <= arb_jtlb_cmp_with_va;
            end else begin
                s2_type_r   <= s2_type_r;
                s2_vpn_r    <= s2_vpn_r;
                s2_cmp_va_r <= s2_cmp_va_r;
            end
            if (lookup_s && !lookup_acc_s) begin
                err_ovr_r <= 1'b1;
            end else begin
                err_ovr_r <= err_ovr_r;
            end
        end
    end

`ifdef CT_MMU_JTLB_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

    logic [31:0] perf_hit_cnt_r;
    logic [31:0] perf_miss_cnt_r;

    // Saturating hit/miss counters advanced on each completion
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            perf_hit_cnt_r  <= 32'd0;
            perf_miss_cnt_r <= 32'd0;
        end else if (|cmplt_nxt_s) begin
            if (hit_nxt_s) begin
                perf_hit_cnt_r <= sat_inc(perf_hit_cnt_r);
            end else begin
                perf_miss_cnt_r <= sat_inc(perf_miss_cnt_r);
            end
        end else begin
            perf_hit_cnt_r  <= perf_hit_cnt_r;
            perf_miss_cnt_r <= perf_miss_cnt_r;
        end
    end

    assign jtlb_perf_hit_cnt  = perf_hit_cnt_r;
    assign jtlb_perf_miss_cnt = perf_miss_cnt_r;
`endif

    assign jtlb_arb_sel_4k     = sel_r[0];
    assign jtlb_arb_sel_2m     = sel_r[1];
    assign jtlb_arb_sel_1g     = sel_r[2];
    assign jtlb_arb_tc_miss    = tc_miss_r;
    assign jtlb_arb_par_clr    = par_clr_r;
    assign jtlb_arb_vpn        = s2_vpn_r;
    assign jtlb_arb_type       = s2_type_r;
    assign jtlb_arb_cmp_va     = s2_cmp_va_r;
    assign jtlb_iutlb_cmplt    = cmplt_r[3];
    assign jtlb_dutlb_cmplt    = cmplt_r[2];
    assign jtlb_arb_pfu_cmplt  = cmplt_r[1];
    assign jtlb_tlboper_cmplt  = cmplt_r[0];
    assign jtlb_xx_hit         = hit_r;
    assign jtlb_xx_hit_bank    = hit_bank_r;
    assign jtlb_err_lookup_ovr = err_ovr_r;

endmodule

// File: tb/tb_ct_mmu_jtlb_resp.sv
// Bench for ct_mmu_jtlb_resp: table of lookup scenarios plus hand-written corner sequences,
// with expected completions queued at issue and checked when the DUT completes.
module tb_ct_mmu_jtlb_resp;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        req, wr, cmp, par_err;
    logic [2:0]  typ;
    logic [27:0] vpn;
    logic [8:0]  idx;
    logic [3:0]  bank_sel, ram_hit;
    logic        cen, wen;
    logic [8:0]  ram_idx;
    logic [3:0]  ram_bank;
    logic        sel_4k, sel_2m, sel_1g, tc_miss, par_clr;
    logic [27:0] arb_vpn;
    logic [2:0]  arb_type;
    logic        arb_cmp_va;
    logic        iu_c, du_c, pfu_c, tlbop_c, xx_hit, err_ovr;
    logic [3:0]  xx_bank;
`ifdef CT_MMU_JTLB_PERF_EN
    logic [31:0] perf_hit, perf_miss;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [2:0]  typ;
        logic [27:0] vpn;
        logic [11:0] hits;     // {1g, 2m, 4k} ram_hit responses
        int          perr;     // level with parity error, 3 = none
        logic [3:0]  e_cmplt;  // {iutlb, dutlb, pfu, tlboper}
        logic        e_hit;
        logic [3:0]  e_bank;
        int          e_lat;
    } vec_t;

    typedef struct {
        logic [3:0] cmplt;
        logic       hit;
        logic [3:0] bank;
        int         cyc;
    } exp_t;

    localparam int NV = 8;
    vec_t vec [NV];
    exp_t sb_q [$];
    exp_t mon_e;
    exp_t new_e;
    logic [3:0] mon_v;

    ct_mmu_jtlb_resp dut (
        .forever_cpuclk      (clk),
        .cpurst_b            (rst_b),
        .arb_jtlb_req        (req),
        .arb_jtlb_acc_type   (typ),
        .arb_jtlb_vpn        (vpn),
        .arb_jtlb_idx        (idx),
        .arb_jtlb_bank_sel   (bank_sel),
        .arb_jtlb_write      (wr),
        .arb_jtlb_cmp_with_va(cmp),
        .jtlb_ram_cen        (cen),
        .jtlb_ram_wen        (wen),
        .jtlb_ram_idx        (ram_idx),
        .jtlb_ram_bank       (ram_bank),
        .ram_hit             (ram_hit),
        .ram_par_err         (par_err),
        .jtlb_arb_sel_4k     (sel_4k),
        .jtlb_arb_sel_2m     (sel_2m),
        .jtlb_arb_sel_1g     (sel_1g),
        .jtlb_arb_tc_miss    (tc_miss),
        .jtlb_arb_par_clr    (par_clr),
        .jtlb_arb_vpn        (arb_vpn),
        .jtlb_arb_type       (arb_type),
        .jtlb_arb_cmp_va     (arb_cmp_va),
        .jtlb_iutlb_cmplt    (iu_c),
        .jtlb_dutlb_cmplt    (du_c),
        .jtlb_arb_pfu_cmplt  (pfu_c),
        .jtlb_tlboper_cmplt  (tlbop_c),
        .jtlb_xx_hit         (xx_hit),
        .jtlb_xx_hit_bank    (xx_bank),
`ifdef CT_MMU_JTLB_PERF_EN
        .jtlb_perf_hit_cnt   (perf_hit),
        .jtlb_perf_miss_cnt  (perf_miss),
`endif
        .jtlb_err_lookup_ovr (err_ovr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        req = 1'b0; wr = 1'b0; cmp = 1'b0; ram_hit = 4'b0000; par_err = 1'b0;
        typ = 3'b000; idx = 9'd0; bank_sel = 4'b0000;
    endtask

    task automatic drive_lookup(input logic [2:0] t, input logic [27:0] v, input logic [8:0] ix);
        req = 1'b1; cmp = 1'b1; wr = 1'b0; typ = t; vpn = v; idx = ix; bank_sel = 4'hF;
    endtask

    task automatic push_exp(input logic [3:0] c, input logic h, input logic [3:0] b, input int at);
        new_e.cmplt = c; new_e.hit = h; new_e.bank = b; new_e.cyc = at;
        sb_q.push_back(new_e);
    endtask

    function automatic vec_t mk(input logic [2:0] t, input logic [27:0] v, input logic [11:0] h,
                                input int pe, input logic [3:0] ec, input logic eh,
                                input logic [3:0] eb, input int lat);
        vec_t r;
        r.typ = t; r.vpn = v; r.hits = h; r.perr = pe;
        r.e_cmplt = ec; r.e_hit = eh; r.e_bank = eb; r.e_lat = lat;
        return r;
    endfunction

    // Scoreboard: every completion pulse must match the oldest queued expectation
    always @(negedge clk) begin
        mon_v = {iu_c, du_c, pfu_c, tlbop_c};
        if (mon_v != 4'b0000) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_cmplt", 32'(mon_v), 32'(4'b0000));
            end else begin
                mon_e = sb_q.pop_front();
                chk("cmplt_route", 32'(mon_v), 32'(mon_e.cmplt));
                chk("cmplt_hit", 32'(xx_hit), 32'(mon_e.hit));
                chk("cmplt_bank", 32'(xx_bank), 32'(mon_e.bank));
                chk("cmplt_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    initial begin
        int  t0;
        bit  done;
        logic [2:0] exp_sel;

        vec[0] = mk(3'b011, 28'h0ABCDEF, {4'h0, 4'h0, 4'b0100}, 3, 4'b1000, 1'b1, 4'b0100, 2);
        vec[1] = mk(3'b010, 28'h1234567, {4'b0001, 4'h0, 4'h0}, 3, 4'b0100, 1'b1, 4'b0001, 6);
        vec[2] = mk(3'b100, 28'h7654321, {4'h0, 4'h0, 4'h0},    3, 4'b0010, 1'b0, 4'b0000, 6);
        vec[3] = mk(3'b011, 28'h0F0F0F0, {4'h0, 4'h0, 4'h0},    1, 4'b1000, 1'b0, 4'b0000, 5);
        vec[4] = mk(3'b001, 28'h5555555, {4'h0, 4'b1000, 4'h0}, 3, 4'b0001, 1'b1, 4'b1000, 4);
        vec[5] = mk(3'b110, 28'hAAAAAAA, {4'h0, 4'h0, 4'h0},    2, 4'b0100, 1'b0, 4'b0000, 7);
        vec[6] = mk(3'b010, 28'h0000001, {4'h0, 4'h0, 4'b0110}, 3, 4'b0100, 1'b1, 4'b0110, 2);
        vec[7] = mk(3'b100, 28'hFFFFFFF, {4'h0, 4'h0, 4'b1111}, 0, 4'b0010, 1'b0, 4'b0000, 3);

        idle_in();
        vpn   = 28'd0;
        rst_b = 1'b0;
        repeat (3) tick();

        // Reset state and RAM pass-through
        chk("rst_sel", 32'({sel_1g, sel_2m, sel_4k}), 32'(3'b001));
        chk("rst_pulses", 32'({tc_miss, par_clr, iu_c, du_c, pfu_c, tlbop_c, xx_hit}), 32'd0);
        chk("rst_saved", 32'({arb_vpn, arb_type, arb_cmp_va}), 32'd0);
        chk("rst_err", 32'(err_ovr), 32'd0);
        chk("rst_bank", 32'(xx_bank), 32'd0);
        req = 1'b1; wr = 1'b1; idx = 9'h1A5; bank_sel = 4'b1010;
        #1;
        chk("ram_pass", 32'({cen, wen, ram_idx, ram_bank}), 32'({1'b1, 1'b1, 9'h1A5, 4'b1010}));
        wr = 1'b0;
        #1;
        chk("ram_rd_wen", 32'({cen, wen}), 32'(2'b10));
        idle_in();
        #1;
        chk("ram_idle_cen", 32'(cen), 32'd0);
        rst_b = 1'b1;
        tick();

        // Table-driven lookups; the bench acts as arbiter and RAM
        for (int i = 0; i < NV; i++) begin
            t0 = cyc;
            push_exp(vec[i].e_cmplt, vec[i].e_hit, vec[i].e_bank, t0 + vec[i].e_lat);
            done = 1'b0;
            for (int l = 0; l < 3 && !done; l++) begin
                if (l == 0) begin
                    chk("issue_sel4k", 32'({sel_1g, sel_2m, sel_4k}), 32'(3'b001));
                    chk("issue_no_tc", 32'(tc_miss), 32'd0);
                end else begin
                    exp_sel = (l == 1) ? 3'b010 : 3'b100;
                    chk("relookup_tc", 32'(tc_miss), 32'd1);
                    chk("relookup_sel", 32'({sel_1g, sel_2m, sel_4k}), 32'(exp_sel));
                    chk("relookup_vpn", 32'(arb_vpn), 32'(vec[i].vpn));
                    chk("relookup_type", 32'({arb_type, arb_cmp_va}), 32'({vec[i].typ, 1'b1}));
                end
                drive_lookup(vec[i].typ, vec[i].vpn, 9'(i));
                tick();
                idle_in();
                ram_hit = vec[i].hits[l*4 +: 4];
                par_err = (vec[i].perr == l);
                done = (vec[i].perr == l) || (ram_hit != 4'b0000) || (l == 2);
                tick();
                idle_in();
            end
            if (vec[i].perr < 3) begin
                exp_sel = (vec[i].perr == 0) ? 3'b010 : ((vec[i].perr == 1) ? 3'b100 : 3'b000);
                chk("parclr_pulse", 32'({par_clr, tc_miss}), 32'(2'b10));
                chk("parclr_sel", 32'({sel_1g, sel_2m, sel_4k}), 32'(exp_sel));
                chk("parclr_vpn", 32'(arb_vpn), 32'(vec[i].vpn));
                tick();
                chk("parclr_one_cycle", 32'(par_clr), 32'd0);
                chk("parclr_back_4k", 32'({sel_1g, sel_2m, sel_4k}), 32'(3'b001));
                repeat (2) tick();
            end else begin
                chk("no_parclr", 32'(par_clr), 32'd0);
                repeat (3) tick();
            end
        end
        chk("err_clean", 32'(err_ovr), 32'd0);

        // Write issued alongside a pending stage-2 lookup
        t0 = cyc;
        push_exp(4'b1000, 1'b1, 4'b0010, t0 + 2);
        drive_lookup(3'b011, 28'h0333333, 9'd3);
        tick();
        idle_in();
        req = 1'b1; wr = 1'b1; cmp = 1'b0; idx = 9'd5; bank_sel = 4'b0100;
        ram_hit = 4'b0010;
        #1;
        chk("wr_pass", 32'({cen, wen, ram_idx, ram_bank}), 32'({1'b1, 1'b1, 9'd5, 4'b0100}));
        tick();
        idle_in();
        repeat (3) tick();
        chk("wr_no_err", 32'(err_ovr), 32'd0);

        // Lookup injected during S2M outside the re-lookup slot
        t0 = cyc;
        push_exp(4'b0100, 1'b1, 4'b0001, t0 + 6);
        drive_lookup(3'b010, 28'h0444444, 9'd4);
        tick(); idle_in();
        tick();
        chk("inj_tc1", 32'(tc_miss), 32'd1);
        drive_lookup(3'b010, 28'h0444444, 9'd4);
        tick(); idle_in();
        drive_lookup(3'b011, 28'h0999999, 9'd9);
        chk("inj_state_2m", 32'({sel_1g, sel_2m, sel_4k, tc_miss}), 32'(4'b0100));
        tick(); idle_in();
        chk("inj_err_set", 32'(err_ovr), 32'd1);
        chk("inj_tc2", 32'(tc_miss), 32'd1);
        chk("inj_sel1g", 32'({sel_1g, sel_2m, sel_4k}), 32'(3'b100));
        chk("inj_vpn_kept", 32'({arb_vpn, arb_type}), 32'({28'h0444444, 3'b010}));
        drive_lookup(3'b010, 28'h0444444, 9'd4);
        tick(); idle_in();
        ram_hit = 4'b0001;
        tick(); idle_in();
        repeat (3) tick();
        chk("inj_err_sticky", 32'(err_ovr), 32'd1);

`ifdef CT_MMU_JTLB_PERF_EN
        chk("perf_hit", perf_hit, 32'd6);
        chk("perf_miss", perf_miss, 32'd4);
`endif

        // Reset pulse while in S1G
        drive_lookup(3'b100, 28'h0777777, 9'd7);
        tick(); idle_in();
        tick();
        drive_lookup(3'b100, 28'h0777777, 9'd7);
        tick(); idle_in();
        tick();
        chk("pre_rst_s1g", 32'({sel_1g, tc_miss}), 32'(2'b11));
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        chk("rst_mid_sel", 32'({sel_1g, sel_2m, sel_4k}), 32'(3'b001));
        chk("rst_mid_pulses", 32'({tc_miss, par_clr, iu_c, du_c, pfu_c, tlbop_c}), 32'd0);
        chk("rst_mid_err", 32'(err_ovr), 32'd0);
`ifdef CT_MMU_JTLB_PERF_EN
        chk("rst_perf", 32'(perf_hit | perf_miss), 32'd0);
`endif
        tick();
        chk("rst_mid_idle", 32'({sel_4k, tc_miss, pfu_c}), 32'(3'b100));

        // Recovery: plain 4K hit after reset
        t0 = cyc;
        push_exp(4'b0010, 1'b1, 4'b1000, t0 + 2);
        drive_lookup(3'b100, 28'h0121212, 9'd12);
        tick(); idle_in();
        ram_hit = 4'b1000;
        tick(); idle_in();
        repeat (3) tick();

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
